// File: rtl/ram_lookup_rd.sv
// Read-side lookup engine for the match/action RAM: issues reads, realigns tags with doutb,
// and buffers results in a credit-guarded FWFT FIFO. Define RAM_LOOKUP_WR_FWD_EN for write forwarding.
module ram_lookup_rd #(
    parameter int ADDR_BITS  = 4,
    parameter int DATA_BITS  = 625,
    parameter int TAG_BITS   = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [TAG_BITS-1:0]  req_tag,
    output logic [ADDR_BITS-1:0] addrb,
    output logic                 enb,
    input  logic [DATA_BITS-1:0] doutb,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_data,
    output logic [TAG_BITS-1:0]  resp_tag,
    output logic [31:0]          rd_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 4;
    localparam int ENT_W = DATA_BITS + TAG_BITS;

    logic                 accept;
    logic [CRD_W-1:0]     inflight;

    logic [RD_LAT-1:0]    vld_q, vld_d;
    logic [TAG_BITS-1:0]  tag_q [RD_LAT];
    logic [TAG_BITS-1:0]  tag_d [RD_LAT];

    logic [ADDR_BITS-1:0] addrb_q, addrb_d;
    logic [31:0]          rd_count_q, rd_count_d;

    logic [ENT_W-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]     fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;

    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] cap_data;

`ifdef RAM_LOOKUP_WR_FWD_EN
    logic [ADDR_BITS-1:0] addr_q [RD_LAT];
    logic [ADDR_BITS-1:0] addr_d [RD_LAT];
    logic [RD_LAT-1:0]    fwd_q, fwd_d;
    logic [DATA_BITS-1:0] fwd_data_q [RD_LAT];
    logic [DATA_BITS-1:0] fwd_data_d [RD_LAT];
`else
    logic                 unused_wr_snoop;
    assign unused_wr_snoop = ^{wr_addr, wr_en, wr_data};
`endif

    // Credits: every in-flight read and every buffered result owns one FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRD_W'(vld_q[i]);
        end
    end

    assign req_ready = !rst && ((inflight + CRD_W'(fifo_count_q)) < CRD_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign enb       = accept;
    assign addrb     = accept ? req_addr : addrb_q;
    assign rd_count  = rd_count_q;

    always_comb begin
        addrb_d    = addrb;
        rd_count_d = accept ? rd_count_q + 32'd1 : rd_count_q;
    end

    // Tag pipeline shifts every cycle; the last stage lines up with doutb.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = accept;
        tag_d[0] = req_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

`ifdef RAM_LOOKUP_WR_FWD_EN
    always_comb begin
        fwd_d         = '0;
        addr_d[0]     = req_addr;
        fwd_d[0]      = wr_en && (wr_addr == req_addr);
        fwd_data_d[0] = wr_data;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_d[i] = addr_q[i-1];
            if (wr_en && vld_q[i-1] && (wr_addr == addr_q[i-1])) begin
                fwd_d[i]      = 1'b1;
                fwd_data_d[i] = wr_data;
            end else begin
                fwd_d[i]      = fwd_q[i-1];
                fwd_data_d[i] = fwd_data_q[i-1];
            end
        end
    end

    // A write landing in the capture cycle is newer than anything already forwarded.
    always_comb begin
        cap_data = doutb;
        if (wr_en && (wr_addr == addr_q[RD_LAT-1])) begin
            cap_data = wr_data;
        end else if (fwd_q[RD_LAT-1]) begin
            cap_data = fwd_data_q[RD_LAT-1];
        end
    end
`else
    assign cap_data = doutb;
`endif

    assign push       = vld_q[RD_LAT-1];
    assign resp_valid = (fifo_count_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = fifo_mem_q[rptr_q][ENT_W-1:TAG_BITS];
    assign resp_tag   = fifo_mem_q[rptr_q][TAG_BITS-1:0];

    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            fifo_mem_d[wptr_q] = {cap_data, tag_q[RD_LAT-1]};
            wptr_d             = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // Control state: cleared on reset, which also discards every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            addrb_q      <= '0;
            rd_count_q   <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fifo_count_q <= '0;
        end else begin
            vld_q        <= vld_d;
            addrb_q      <= addrb_d;
            rd_count_q   <= rd_count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // Datapath storage: qualified by the valids above, so no reset.
    always_ff @(posedge clk) begin
        tag_q      <= tag_d;
        fifo_mem_q <= fifo_mem_d;
`ifdef RAM_LOOKUP_WR_FWD_EN
        addr_q     <= addr_d;
        fwd_q      <= fwd_d;
        fwd_data_q <= fwd_data_d;
`endif
    end

endmodule

// File: tb/tb_ram_lookup_rd.sv
// Directed bench for ram_lookup_rd with a read-first single-cycle RAM model on the B port.
module tb_ram_lookup_rd;

    localparam int AB = 4;
    localparam int DB = 625;
    localparam int TB = 8;
    localparam int RL = 1;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AB-1:0] req_addr;
    logic [TB-1:0] req_tag;
    logic [AB-1:0] addrb;
    logic          enb;
    logic [DB-1:0] doutb;
    logic [AB-1:0] wr_addr;
    logic          wr_en;
    logic [DB-1:0] wr_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DB-1:0] resp_data;
    logic [TB-1:0] resp_tag;
    logic [31:0]   rd_count;

    logic [DB-1:0] ram [16];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        if (enb)   doutb <= ram[addrb];
    end

    ram_lookup_rd #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB), .RD_LAT(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
        .addrb(addrb), .enb(enb), .doutb(doutb),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .rd_count(rd_count)
    );

    function automatic logic [DB-1:0] mk(input int s);
        logic [639:0] t;
        logic [31:0]  w;
        w = 32'(s) * 32'h0101_0101 + 32'h1234_5677;
        t = {20{w}};
        t[31:0] = ~w;
        return t[DB-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; wr_en = 1'b0;
        req_addr = '0; req_tag = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_vec++; if (rd_count !== 32'd0) begin n_err++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
        n_vec++; if (enb !== 1'b0) begin n_err++; $display("FAIL reset_enb: got %b want 0", enb); end
        n_vec++; if (addrb !== '0) begin n_err++; $display("FAIL reset_addrb: got %0d want 0", addrb); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        rst = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
        @(negedge clk);
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = AB'(i); wr_data = mk(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        bit found;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 4'd3; req_tag = 8'h5A;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", req_ready); end
        n = 0; found = 0;
        while (!found && n < 8) begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
            if (resp_valid === 1'b1) found = 1;
        end
        n_vec++; if (!found || n != RL + 1) begin n_err++; $display("FAIL single_latency: got %0d cycles want %0d", n, RL + 1); end
        n_vec++; if (resp_data !== mk(3)) begin n_err++; $display("FAIL single_data: got %h want %h", resp_data, mk(3)); end
        n_vec++; if (resp_tag !== 8'h5A) begin n_err++; $display("FAIL single_tag: got %h want 5a", resp_tag); end
        n_vec++; if (rd_count !== 32'd1) begin n_err++; $display("FAIL single_rd_count: got %0d want 1", rd_count); end
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_pop: got %b want 0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        int got, gaps, stray;
        got = 0; gaps = 0; stray = 0;
        resp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                req_valid = 1'b1; req_addr = AB'(c); req_tag = TB'(c);
                n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", c, req_ready); end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (got < 8) begin
                    n_vec++; if (resp_tag !== TB'(got)) begin n_err++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", got, resp_tag, got); end
                    n_vec++; if (resp_data !== mk(got)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", got, resp_data, mk(got)); end
                end else begin
                    stray++;
                end
                got++;
            end else if (got > 0 && got < 8) begin
                gaps++;
            end
        end
        req_valid = 1'b0;
        n_vec++; if (got != 8 || stray != 0) begin n_err++; $display("FAIL b2b_count: got %0d responses want 8", got); end
        n_vec++; if (gaps != 0) begin n_err++; $display("FAIL b2b_gaps: got %0d idle cycles want 0", gaps); end
    endtask

    task automatic test_backpressure();
        int acc, got;
        acc = 0; got = 0;
        resp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_addr = AB'(8 + acc); req_tag = TB'(8'h10 + acc);
            if (req_ready === 1'b1) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_vec++; if (acc != FD) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", acc, FD); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", req_ready); end
        n_vec++; if (resp_valid !== 1'b1 || resp_tag !== 8'h10) begin n_err++; $display("FAIL bp_head: got valid=%b tag=%h want valid=1 tag=10", resp_valid, resp_tag); end
        n_vec++; if (rd_count !== 32'd13) begin n_err++; $display("FAIL bp_rd_count: got %0d want 13", rd_count); end
        resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid === 1'b1) begin
                n_vec++; if (resp_tag !== TB'(8'h10 + got)) begin n_err++; $display("FAIL bp_tag[%0d]: got %h want %h", got, resp_tag, 8'h10 + got); end
                n_vec++; if (resp_data !== mk(8 + got)) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", got, resp_data, mk(8 + got)); end
                got++;
            end
            @(negedge clk);
        end
        n_vec++; if (got != FD) begin n_err++; $display("FAIL bp_drained: got %0d want %0d", got, FD); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 4'd1; req_tag = 8'hA1;
        @(negedge clk);
        req_addr = 4'd2; req_tag = 8'hA2;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_resp_valid: got %b want 0", resp_valid); end
        n_vec++; if (rd_count !== 32'd0) begin n_err++; $display("FAIL mid_rst_rd_count: got %0d want 0", rd_count); end
        n_vec++; if (addrb !== '0 || enb !== 1'b0) begin n_err++; $display("FAIL mid_rst_port: got addrb=%0d enb=%b want 0 0", addrb, enb); end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) stale++;
        end
        n_vec++; if (stale != 0) begin n_err++; $display("FAIL mid_rst_stale: got %0d stale cycles want 0", stale); end
    endtask

    task automatic test_collision();
        int n;
        logic [DB-1:0] exp_d;
`ifdef RAM_LOOKUP_WR_FWD_EN
        exp_d = mk(100);
`else
        exp_d = mk(2);
`endif
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 4'd2; req_tag = 8'hC2;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = mk(100);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0; wr_en = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (resp_valid !== 1'b1 || resp_tag !== 8'hC2) begin n_err++; $display("FAIL coll_tag: got valid=%b tag=%h want valid=1 tag=c2", resp_valid, resp_tag); end
        n_vec++; if (resp_data !== exp_d) begin n_err++; $display("FAIL coll_data: got %h want %h", resp_data, exp_d); end
        @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        force dut.rd_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_count_q;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 4'd5; req_tag = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (rd_count !== 32'd0) begin n_err++; $display("FAIL wrap_rd_count: got %h want 0", rd_count); end
        repeat (3) @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drain: got %b want 0", resp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        preload();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_collision();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
